// File: rtl/speck_pkg.sv
// Shared Speck constants, FSM state type and word-width-generic rotate helpers.
// The rotate helpers work on up to 64-bit words; callers truncate the result to their own width.
package speck_pkg;

  localparam int SPECK_W      = 32;
  localparam int SPECK_ROUNDS = 27;
  localparam int SPECK_ALPHA  = 8;
  localparam int SPECK_BETA   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n,
                                      input int unsigned w);
    logic [63:0] mask;
    logic [63:0] xm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    return ((xm >> n) | (xm << (w - n))) & mask;
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] x, input int unsigned n,
                                      input int unsigned w);
    logic [63:0] mask;
    logic [63:0] xm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    return ((xm << n) | (xm >> (w - n))) & mask;
  endfunction

endpackage

// File: rtl/speck_round.sv
// Combinational Speck round: x' = (ROR(x,ALPHA)+y) ^ key, y' = ROL(y,BETA) ^ x'.
// Shared by the key schedule (x=l[0], y=k, key=i) and the cipher datapath.
module speck_round
  import speck_pkg::*;
#(
  parameter int W     = SPECK_W,
  parameter int ALPHA = SPECK_ALPHA,
  parameter int BETA  = SPECK_BETA
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] key_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);

  logic [W-1:0] x_ror;
  logic [W-1:0] y_rol;

  assign x_ror = W'(ror(64'(x_i), ALPHA, W));
  assign y_rol = W'(rol(64'(y_i), BETA, W));
  assign x_o   = (x_ror + y_i) ^ key_i;
  assign y_o   = y_rol ^ x_o;

endmodule

// File: rtl/speck_key_schedule.sv
// Iterative Speck key expansion: one round key per clock, done pulses ROUNDS-1 cycles after start.
// start is ignored while busy; define SPECK_KS_ROUND_IDX_EN to expose the last-written key index.
module speck_key_schedule
  import speck_pkg::*;
#(
  parameter int W      = SPECK_W,
  parameter int ROUNDS = SPECK_ROUNDS,
  parameter int ALPHA  = SPECK_ALPHA,
  parameter int BETA   = SPECK_BETA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          K0,
  input  logic [W-1:0]          K1,
  input  logic [W-1:0]          K2,
  input  logic [W-1:0]          K3,
  output logic [W*ROUNDS-1:0]   rk_flat,
  output logic                  busy,
  output logic                  done
`ifdef SPECK_KS_ROUND_IDX_EN
  ,
  output logic [$clog2(ROUNDS)-1:0] round_idx
`endif
);

  localparam int CW = $clog2(ROUNDS);

  state_e                state_q;
  logic [W-1:0]          k_q;
  logic [2:0][W-1:0]     l_q;
  logic [CW-1:0]         i_q;
  logic [W*ROUNDS-1:0]   rk_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CW-1:0]         wr_idx_d;
  logic [W-1:0]          rc_d;
  logic [W-1:0]          l_new_d;
  logic [W-1:0]          k_next_d;

  assign wr_idx_d = i_q + 1'b1;
  assign rc_d     = {{(W-CW){1'b0}}, i_q};

  speck_round #(
    .W    (W),
    .ALPHA(ALPHA),
    .BETA (BETA)
  ) u_round (
    .x_i  (l_q[0]),
    .y_i  (k_q),
    .key_i(rc_d),
    .x_o  (l_new_d),
    .y_o  (k_next_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      l_q     <= '0;
      i_q     <= '0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            k_q          <= K0;
            l_q          <= {K3, K2, K1};
            rk_q[0 +: W] <= K0;
            i_q          <= '0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          rk_q[wr_idx_d*W +: W] <= k_next_d;
          k_q                   <= k_next_d;
          // l-queue: oldest word leaves at l[0], fresh l_new enters at l[2]
          l_q                   <= {l_new_d, l_q[2], l_q[1]};
          i_q                   <= wr_idx_d;
          if (i_q == CW'(ROUNDS - 2)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPECK_KS_ROUND_IDX_EN
  logic [CW-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (state_q == IDLE && start) begin
      idx_q <= '0;
    end else if (state_q == RUN) begin
      idx_q <= wr_idx_d;
    end
  end

  assign round_idx = idx_q;
`endif

  assign rk_flat = rk_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_speck_key_schedule.sv
// Directed bench for speck_key_schedule with an independent Speck64/128 reference model.
module tb_speck_key_schedule;

  localparam int W  = 32;
  localparam int R  = 27;
  localparam int NB = W * R;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  K0, K1, K2, K3;
  logic [NB-1:0] rk_flat;
  logic          busy;
  logic          done;
`ifdef SPECK_KS_ROUND_IDX_EN
  logic [4:0]    round_idx;
`endif

  speck_key_schedule dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .K0     (K0),
    .K1     (K1),
    .K2     (K2),
    .K3     (K3),
    .rk_flat(rk_flat),
    .busy   (busy),
    .done   (done)
`ifdef SPECK_KS_ROUND_IDX_EN
    ,
    .round_idx(round_idx)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] sb[$];

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook formulation with a growing l[] array rather than a shift queue.
  function automatic logic [NB-1:0] ref_ks(input logic [31:0] k0, k1, k2, k3);
    logic [31:0]   k[R];
    logic [31:0]   l[R+2];
    logic [NB-1:0] o;
    k[0] = k0; l[0] = k1; l[1] = k2; l[2] = k3;
    for (int i = 0; i < R - 1; i++) begin
      l[i+3] = (k[i] + rr(l[i], 8)) ^ 32'(i);
      k[i+1] = rl(k[i], 3) ^ l[i+3];
    end
    o = '0;
    for (int i = 0; i < R; i++) o[i*32 +: 32] = k[i];
    return o;
  endfunction

  function automatic logic [63:0] enc(input logic [NB-1:0] rkv, input logic [63:0] pt);
    logic [31:0] x, y;
    x = pt[63:32]; y = pt[31:0];
    for (int i = 0; i < R; i++) begin
      x = (rr(x, 8) + y) ^ rkv[i*32 +: 32];
      y = rl(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_ks(input logic [31:0] a, b, c, d, input bit push);
    K0 = a; K1 = b; K2 = c; K3 = d;
    start = 1'b1;
    if (push) sb.push_back(ref_ks(a, b, c, d));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output int nbusy);
    n = -1;
    nbusy = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (done) begin
        n = c;
        return;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [NB-1:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_expected_entry expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, rk_flat, exp);
    end
  endtask

  initial begin
    logic [NB-1:0] ka;
    int n, nb, dn;

    rst = 1'b1; start = 1'b0;
    K0 = '0; K1 = '0; K2 = '0; K3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rk_flat", rk_flat, '0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference vector
    ka = ref_ks(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918);
    start_ks(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918, 1);
    chk("t1_busy_rise", busy, 1);
    chk("t1_rk0", rk_flat[31:0], 32'h03020100);
`ifdef SPECK_KS_ROUND_IDX_EN
    chk("t1_idx_start", round_idx, 0);
`endif
    wait_done(60, n, nb);
    chk("t1_latency", n, 26);
    chk("t1_busy_cycles", nb, 25);
    chk("t1_busy_at_done", busy, 0);
`ifdef SPECK_KS_ROUND_IDX_EN
    chk("t1_idx_done", round_idx, 26);
`endif
    chk("t1_rk1", rk_flat[63:32], 32'h131d0309);
    chk("t1_rk2", rk_flat[95:64], 32'hbbd80d53);
    chk("t1_encrypt", enc(rk_flat, 64'h3b726574_7475432d), 64'h8c6fa548_454e028b);
    check_result("t1_keys");
    @(posedge clk); #1;
    chk("t1_done_single", done, 0);
    repeat (19) begin @(posedge clk); #1; end
    chk("t1_rk_stable", rk_flat, ka);

    // Start while busy is ignored
    start_ks(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918, 1);
    repeat (9) begin @(posedge clk); #1; end
    start_ks(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d, 0);
    wait_done(60, n, nb);
    chk("t2_latency", n, 16);
    check_result("t2_keys");
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("t2_no_extra_done", dn, 0);

    // Reset mid-expansion
    start_ks(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0);
    repeat (11) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("t3_rst_rk_flat", rk_flat, '0);
    chk("t3_rst_busy", busy, 0);
    chk("t3_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_ks(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918, 1);
    wait_done(60, n, nb);
    chk("t3_latency", n, 26);
    chk("t3_rk1", rk_flat[63:32], 32'h131d0309);
    check_result("t3_keys");

    // All-zero key
    start_ks(32'h0, 32'h0, 32'h0, 32'h0, 1);
    wait_done(60, n, nb);
    chk("t4_latency", n, 26);
    chk("t4_rk0", rk_flat[31:0], 32'h0);
    chk("t4_rk1", rk_flat[63:32], 32'h0);
    chk("t4_rk2", rk_flat[95:64], 32'h1);
    check_result("t4_keys");

    // Back-to-back: start on the done cycle
    start_ks(32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918, 1);
    wait_done(60, n, nb);
    chk("t5_first_latency", n, 26);
    check_result("t5_first_keys");
    start_ks(32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0f0f0f0f, 32'hf0f0f0f0, 1);
    chk("t5_busy_rise", busy, 1);
    chk("t5_done_fall", done, 0);
    chk("t5_rk0", rk_flat[31:0], 32'ha5a5a5a5);
    wait_done(60, n, nb);
    chk("t5_second_latency", n, 26);
    check_result("t5_second_keys");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speck_key_schedule.md
Name: speck_key_schedule

Overview:
- Iterative Speck64/128 key-expansion engine: four 32-bit master key words in, ROUNDS round keys out as one flat bus.
- Sits between the key-load logic (UART command path) and the Speck encrypt/decrypt datapath, which reads rk_flat after done.
- Produces one round key per clock using the Speck round function, with key word K0 as the round key input and the round index as the constant.

Parameters:
- W, 32, word width in bits; valid values 16/24/32/48/64.
- ROUNDS, 27, number of round keys generated; minimum 2.
- ALPHA, 8, right-rotate amount (7 when W=16).
- BETA, 3, left-rotate amount (2 when W=16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to expand the current key.
- K0  in  W  key word k[0]; also round key 0.
- K1  in  W  key word l[0].
- K2  in  W  key word l[1].
- K3  in  W  key word l[2], the most significant key word.
- rk_flat  out  W*ROUNDS  round key i at rk_flat[i*W +: W].
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when all round keys are valid.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: rk_flat=0, busy=0, done=0, internal k/l registers=0, round counter=0.
- Arithmetic: all arithmetic is modulo 2^W. ROR and ROL are rotations within W bits.
- Recurrence, for i = 0..ROUNDS-2:
  - l_new = (k + ROR(l[0], ALPHA)) XOR i
  - k_next = ROL(k, BETA) XOR l_new
  - the l-queue shifts: l[0] <= l[1], l[1] <= l[2], l[2] <= l_new
- States: IDLE and RUN.
- IDLE:
  - start=1 at edge T0 captures k=K0 and l[0..2]=K1..K3.
  - The same edge writes rk[0]=K0, sets i=0 and busy=1, and moves to RUN.
- RUN:
  - Each edge writes rk[i+1]=k_next, updates k and the l-queue, and increments i.
  - At edge T0+ROUNDS-1, rk[ROUNDS-1] is written, busy falls, and done=1 for exactly one cycle. The block returns to IDLE.
- Total latency: start edge to done high is ROUNDS-1 cycles (26 by default).
- start is ignored while busy=1. K0..K3 are sampled only at the start edge; later changes have no effect.
- rk_flat:
  - holds its value after done until the next accepted start;
  - on a new start, entries are overwritten progressively, not cleared.
- start asserted in the same cycle as done: accepted (the block is in IDLE on that edge). done falls and busy rises.
- Reset mid-expansion: all outputs return to reset values immediately; no done pulse.
- Counter width: clog2(ROUNDS). The round-constant XOR uses i zero-extended to W.

Optional Feature:
- Macro: SPECK_KS_ROUND_IDX_EN.
- Defined: adds output round_idx (width clog2(ROUNDS)).
  - It holds the index of the most recently written round key.
  - It is 0 after reset and after start, and ROUNDS-1 when done pulses.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package speck_pkg holds:
  - default constants SPECK_W=32, SPECK_ROUNDS=27, SPECK_ALPHA=8, SPECK_BETA=3;
  - the state enum (IDLE, RUN);
  - ror/rol functions parameterized by width.
- Sub-module speck_round (combinational):
  - inputs x, y, key; outputs x', y';
  - computes x' = (ROR(x,ALPHA)+y) XOR key and y' = ROL(y,BETA) XOR x'.
  - The key schedule instantiates it with x=l[0], y=k, key=i. The cipher datapath reuses it.

Test Plan:
- Reset then vector: K3=1b1a1918, K2=13121110, K1=0b0a0908, K0=03020100, start pulse.
  - Expect rk[0]=03020100, rk[1]=131d0309, rk[2]=bbd80d53.
  - Expect done exactly 26 cycles after the start edge.
  - All 27 keys must match the Speck64/128 reference model; encrypting 3b726574_7475432d with them gives 8c6fa548_454e028b.
- Busy/done timing with the default vector:
  - busy high for 26 cycles;
  - done a single one-cycle pulse coinciding with busy falling;
  - rk_flat stable for 20 cycles after done.
- Start while busy: pulse start at cycle 10 with different K inputs -> ignored; results equal the first test's keys; done fires once.
- Reset mid-run: assert rst at cycle 12 -> rk_flat=0, busy=0, done=0 immediately. A new start then reproduces rk[1]=131d0309.
- All-zero key: K0..K3=0 -> rk[0]=0 and rk[1]=0 (since i=0). rk[2]=1, the constant XOR propagating (l_new=1, k_next=ROL(0,3) XOR 1). All remaining keys match the reference model.
- Back-to-back: start asserted on the done cycle with a new key -> accepted; busy rises the next cycle; the second result set is correct.
